div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; only 32 is supported.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair present.
REQ-005 in_ready  output  1  unit can accept operands.
REQ-006 dividend  input  WIDTH  numerator.
REQ-007 divisor  input  WIDTH  denominator.
REQ-008 is_signed  input  1  treat operands as two's complement; sampled with operands.
REQ-009 out_valid  output  1  quotient/remainder valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 quotient  output  WIDTH  result quotient.
REQ-012 remainder  output  WIDTH  result remainder.

Function
REQ-013 The unit SHALL be an iterative radix-2 restoring divider with states IDLE, CALC and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; operands are accepted on an edge where in_valid=1 and in_ready=1.
REQ-015 On accept, the unit SHALL latch the operand magnitudes and the result signs, clear the iteration counter, and enter CALC.
REQ-016 In CALC, each edge SHALL shift one dividend bit into the partial remainder and subtract the divisor magnitude if non-negative.
REQ-017 After WIDTH iterations, CALC SHALL enter DONE, so out_valid rises exactly WIDTH edges after the accept edge.
REQ-018 Divisor=0 SHALL bypass CALC, reaching DONE 1 edge after accept with quotient=all ones and remainder=dividend (unmodified).
REQ-019 Signed overflow (dividend=0x80000000, divisor=0xFFFFFFFF, is_signed=1) SHALL bypass CALC, reaching DONE 1 edge after accept with quotient=0x80000000 and remainder=0.
REQ-020 Signed quotient SHALL truncate toward zero; remainder SHALL carry the sign of the dividend; sign correction SHALL be applied on the final CALC edge.
REQ-021 In DONE, out_valid SHALL be 1 and quotient/remainder SHALL hold stable until out_ready=1.
REQ-022 The edge with out_valid=1 and out_ready=1 SHALL return the unit to IDLE; in_ready SHALL be 1 in the following cycle (no same-cycle turnaround).
REQ-023 in_valid SHALL be ignored outside IDLE; operand changes during CALC/DONE SHALL NOT affect the result.
REQ-024 quotient and remainder SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-025 While rst_n=0, the state SHALL be IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, and the counter=0.
REQ-026 Reset asserted mid-CALC or in DONE SHALL abort the operation and discard the result; no out_valid follows the release.
REQ-027 Reset deassertion SHALL take effect on the next clk edge; the first operand accept may occur on that edge.

Configuration
REQ-028 Macro DIV_UNIT_SIGNED_EN: when defined, is_signed SHALL be honoured per REQ-019 and REQ-020.
REQ-029 When DIV_UNIT_SIGNED_EN is undefined, the is_signed port SHALL remain present but be ignored; all operations SHALL be unsigned and REQ-019 SHALL NOT apply.

Verification
REQ-030 Unsigned 100/7, out_ready=1 -> quotient=14, remainder=2; out_valid 32 edges after accept; in_ready=1 the cycle after the result handshake.
REQ-031 5/0 -> quotient=0xFFFFFFFF, remainder=5, out_valid 1 edge after accept; same result with is_signed=1.
REQ-032 Signed 0xFFFFFFF9/2 (-7/2) with DIV_UNIT_SIGNED_EN -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; without the macro -> quotient=0x7FFFFFFC, remainder=1.
REQ-033 Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, out_valid 1 edge after accept.
REQ-034 out_ready held 0 for 5 cycles in DONE -> out_valid, quotient and remainder stable, in_ready=0; a new in_valid with other operands is not accepted.
REQ-035 rst_n pulsed low at CALC iteration 10 -> out_valid=0 and in_ready=1 immediately; 0xFFFFFFFF/1 issued after release -> quotient=0xFFFFFFFF, remainder=0.

Source files
------------

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//
// Iterative radix-2 restoring divider. It produces one quotient bit per clock,
// so a full operation takes WIDTH cycles in CALC. There are two bypass cases,
// and each finishes one edge after accept:
//   * divisor == 0       -> quotient = all ones, remainder = dividend (raw bits)
//   * signed overflow    -> quotient = most-negative value, remainder = 0
//     (this case applies only when signed support is compiled in)
//
// Configuration macro:
//   DIV_UNIT_SIGNED_EN  - when defined, is_signed is honoured. The quotient
//                         truncates toward zero and the remainder takes the sign
//                         of the dividend. When the macro is undefined, the port
//                         is still present but every operation is unsigned.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair present
//   in_ready   unit can accept operands (high only in IDLE)
//   dividend   numerator, WIDTH bits
//   divisor    denominator, WIDTH bits
//   is_signed  treat operands as two's complement (sampled on accept)
//   out_valid  quotient/remainder valid (high only in DONE)
//   out_ready  consumer accepts the result
//   quotient   registered quotient, WIDTH bits
//   remainder  registered remainder, WIDTH bits
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    // Signed views of the operands. They are used only to find the sign and
    // the magnitude.
    logic signed [WIDTH-1:0] dividend_s;
    logic signed [WIDTH-1:0] divisor_s;

    logic op_signed;
    logic accept;
    logic div_zero;
    logic div_ovf;

    // Iteration state
    logic [WIDTH-1:0] dvd_q;     // dividend magnitude; quotient bits shift in at the LSB
    logic [WIDTH-1:0] dvs_q;     // divisor magnitude
    logic [WIDTH-1:0] rem_q;     // partial remainder, always < dvs_q
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             byp_zero_q;
    logic             byp_ovf_q;
    logic [CNT_W-1:0] cnt_q;

    // One restoring step
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] dvd_next;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    // Magnitude of a two's complement value. For the most-negative value, the
    // unsigned bit pattern is already the correct magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic                    sgn);
        logic signed [WIDTH-1:0] neg_v;
        neg_v = -v;
        if (sgn && (v < 0))
            magnitude = neg_v;
        else
            magnitude = v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                    input logic             neg);
        if (neg)
            apply_sign = ~mag + WIDTH'(1);
        else
            apply_sign = mag;
    endfunction

    // -------------------------------------------------------------------------
    // Operand qualification
    // -------------------------------------------------------------------------
`ifdef DIV_UNIT_SIGNED_EN
    assign op_signed = is_signed;
`else
    assign op_signed = is_signed & 1'b0;
`endif

    assign dividend_s = dividend;
    assign divisor_s  = divisor;

    assign accept   = in_valid && (state == IDLE);
    assign div_zero = (divisor == '0);
    assign div_ovf  = op_signed && (dividend == MIN_NEG) && (divisor == ALL_ONES);

    // -------------------------------------------------------------------------
    // Restoring step. The shifted value can be up to WIDTH+1 bits wide. When its
    // top bit is set, it is certainly >= the divisor. The subtraction result
    // always fits in WIDTH bits, so a WIDTH-bit difference is enough.
    // -------------------------------------------------------------------------
    always_comb begin
        shifted  = {rem_q, dvd_q[WIDTH-1]};
        diff     = shifted[WIDTH-1:0] - dvs_q;
        fits     = shifted[WIDTH] || (shifted[WIDTH-1:0] >= dvs_q);
        rem_next = fits ? diff : shifted[WIDTH-1:0];
        dvd_next = {dvd_q[WIDTH-2:0], fits};
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (in_valid) state_next = CALC;
            CALC: if (byp_zero_q || byp_ovf_q || (cnt_q == LAST_ITER)) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // -------------------------------------------------------------------------
    // Control and result registers (reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            byp_zero_q <= 1'b0;
            byp_ovf_q  <= 1'b0;
            quotient   <= '0;
            remainder  <= '0;
        end else if (accept) begin
            cnt_q      <= '0;
            byp_zero_q <= div_zero;
            byp_ovf_q  <= div_ovf;
        end else if (state == CALC) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (byp_zero_q) begin
                quotient  <= ALL_ONES;
                remainder <= dvd_q;
            end else if (byp_ovf_q) begin
                quotient  <= MIN_NEG;
                remainder <= '0;
            end else if (cnt_q == LAST_ITER) begin
                quotient  <= apply_sign(dvd_next, neg_quo_q);
                remainder <= apply_sign(rem_next, neg_rem_q);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Iteration datapath (no reset; every field is loaded on accept)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            // A zero divisor must return the dividend unmodified, so the raw
            // bits are kept instead of the magnitude.
            dvd_q     <= div_zero ? dividend : magnitude(dividend_s, op_signed);
            dvs_q     <= magnitude(divisor_s, op_signed);
            rem_q     <= '0;
            neg_quo_q <= op_signed && ((dividend_s < 0) != (divisor_s < 0));
            neg_rem_q <= op_signed && (dividend_s < 0);
        end else if (state == CALC) begin
            dvd_q <= dvd_next;
            rem_q <= rem_next;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
//
// Testbench for div_unit. It applies directed and $urandom operand pairs and
// compares every result against a plain-arithmetic reference model. Each
// operation also checks latency, result stability under backpressure, the
// handshake turnaround, and reset abort behaviour. The model follows
// DIV_UNIT_SIGNED_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int errors = 0;
    int checks = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: integer division as defined for the unit.
    function automatic void model(input  logic [31:0] a,
                                  input  logic [31:0] b,
                                  input  logic        s,
                                  output logic [31:0] q,
                                  output logic [31:0] r,
                                  output int          lat);
        logic sg;
        int   sa;
        int   sb;
`ifdef DIV_UNIT_SIGNED_EN
        sg = s;
`else
        sg = 1'b0;
`endif
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            lat = 1;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
            lat = 1;
        end else if (sg) begin
            q = sa / sb;
            r = sa % sb;
            lat = 32;
        end else begin
            q = a / b;
            r = a % b;
            lat = 32;
        end
    endfunction

    // One full transaction. 'hold' is the number of DONE cycles during which
    // out_ready stays low before the result is taken.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int hold);
        logic [31:0] eq;
        logic [31:0] er;
        int          elat;
        int          n;
        model(a, b, s, eq, er, elat);

        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);

        dividend  = a;
        divisor   = b;
        is_signed = s;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        // Scramble the inputs after accept; they must not affect the result.
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom_range(0, 1));
        in_valid  = 1'($urandom_range(0, 1));
        check("in_ready_busy", {31'd0, in_ready}, 32'd0);

        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
            in_valid = 1'($urandom_range(0, 1));
            dividend = $urandom;
        end
        check("latency", n, elat);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);

        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            dividend = $urandom;
            divisor  = $urandom;
            @(posedge clk); #1;
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_quotient", quotient, eq);
            check("hold_remainder", remainder, er);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("turnaround_in_ready", {31'd0, in_ready}, 32'd1);
        check("turnaround_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        is_signed = 1'b0;
        #2 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        rst_n = 1'b1;

        // Directed cases
        run_op(32'd100, 32'd7, 1'b0, 0);
        run_op(32'd5, 32'd0, 1'b0, 0);
        run_op(32'd5, 32'd0, 1'b1, 0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(32'hFFFF_FFFB, 32'd0, 1'b1, 0);
        run_op(-32'sd100, -32'sd7, 1'b1, 0);
        run_op(32'd100, -32'sd7, 1'b1, 0);
        run_op(32'h8000_0000, 32'd2, 1'b1, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(32'd3, 32'd10, 1'b0, 0);
        // Backpressure: result held for 5 cycles with a competing request
        run_op(32'd123456, 32'd789, 1'b0, 5);

        // Reset in the middle of CALC
        dividend  = 32'h1234_5678;
        divisor   = 32'd3;
        is_signed = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_quotient", quotient, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_result", seen, 32'd0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);

        // Randomized operations
        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: rb = $urandom_range(1, 1000);
                default: rb = $urandom;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
